seg7_scan_capture: RTL and testbench

Reads back the multiplexed 7-segment drive (active-low anodes plus cathodes) that the game's display scanner produces and reconstructs the four displayed characters as raw segment patterns and hex values. It is the receive end of the display scan interface. It sits beside the display driver for self-check and scoreboard logic, and feeds the bench monitor and an on-chip "display agrees with game state" checker. Scan timing is not fixed: the block locks to whatever anode rotation it observes.

---
 rtl/seg7_scan_capture.sv | 238 +++++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Receive end of the multiplexed 7-segment scan interface. It watches the
// active-low anode/cathode drive, locks to whatever digit rotation it sees,
// and rebuilds the four displayed characters once every digit has been
// captured.
//
// Parameters
//   SETTLE_CYCLES  : cycles a pattern must hold before capture (>= 1)
//   TIMEOUT_CYCLES : cycles without capture before stale is raised
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   anodes[3:0]     : active-low digit enables (1110 = digit 3 ... 0111 = digit 0)
//   cathodes[6:0]   : active-low segments {a..g}, bit 6 = a
//   seg_raw[27:0]   : last complete frame {d3,d2,d1,d0}
//   digit_value     : hex decode per digit, digit 3 in [15:12]
//   digit_known     : digit matched a hex glyph
//   digit_blank     : digit was all segments off
//   frame_strobe    : one-cycle pulse when frame outputs update
//   frame_changed   : pulse with frame_strobe when seg_raw changed
//   stale           : no capture for TIMEOUT_CYCLES
//   glitch_count    : saturating count of illegal anode pattern entries
module seg7_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anodes,
  input  logic [6:0]  cathodes,
  output logic [27:0] seg_raw,
  output logic [15:0] digit_value,
  output logic [3:0]  digit_known,
  output logic [3:0]  digit_blank,
  output logic        frame_strobe,
  output logic        frame_changed,
  output logic        stale,
  output logic [7:0]  glitch_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_MAX  = SCW'(SETTLE_CYCLES);
  localparam logic [SCW-1:0] SCNT_ONE    = SCW'(1);
  localparam logic [TCW-1:0] TIMEOUT_MAX = TCW'(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TCNT_ONE    = TCW'(1);

  // Returns {known, blank, value[3:0]} for one received glyph.
  function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'b0000001: res = {2'b10, 4'h0};
      7'b1001111: res = {2'b10, 4'h1};
      7'b0010010: res = {2'b10, 4'h2};
      7'b0000110: res = {2'b10, 4'h3};
      7'b1001100: res = {2'b10, 4'h4};
      7'b0100100: res = {2'b10, 4'h5};
      7'b0100000: res = {2'b10, 4'h6};
      7'b0001111: res = {2'b10, 4'h7};
      7'b0000000: res = {2'b10, 4'h8};
      7'b0000100: res = {2'b10, 4'h9};
      7'b0001000: res = {2'b10, 4'hA};
      7'b1100000: res = {2'b10, 4'hB};
      7'b0110001: res = {2'b10, 4'hC};
      7'b1000010: res = {2'b10, 4'hD};
      7'b0110000: res = {2'b10, 4'hE};
      7'b0111000: res = {2'b10, 4'hF};
      7'b1111111: res = {2'b01, 4'h0};
      default:    res = {2'b00, 4'h0};
    endcase
    return res;
  endfunction

  logic [3:0]     anodes_r, prev_anodes_r;
  logic [6:0]     cathodes_r, prev_cathodes_r;
  logic [1:0]     state_r, state_nxt_s;
  logic [SCW-1:0] scnt_r, scnt_nxt_s, cnt_new_s;
  logic [TCW-1:0] tcnt_r, tcnt_nxt_s;
  logic [6:0]     shadow_r [4];
  logic [3:0]     seen_r, seen_set_s;
  logic [1:0]     digit_s;
  logic           single_s, dark_s, illegal_s;
  logic           same_anodes_s, same_pat_s;
  logic           go_s, capture_s, frame_done_s;
  logic [27:0]    frame_s;

  // Classify the registered anode pattern and pick the enabled digit.
  always_comb begin
    single_s = 1'b1;
    digit_s  = 2'd0;
    case (anodes_r)
      4'b1110: digit_s = 2'd3;
      4'b1101: digit_s = 2'd2;
      4'b1011: digit_s = 2'd1;
      4'b0111: digit_s = 2'd0;
      default: single_s = 1'b0;
    endcase
    dark_s        = (anodes_r == 4'b1111);
    illegal_s     = !single_s && !dark_s;
    same_anodes_s = (anodes_r == prev_anodes_r);
    same_pat_s    = same_anodes_s && (cathodes_r == prev_cathodes_r);
  end

  // Scan-lock FSM: decide whether the current pattern keeps settling,
  // restarts, or reaches capture.
  always_comb begin
    state_nxt_s = state_r;
    scnt_nxt_s  = scnt_r;
    cnt_new_s   = SCNT_ONE;
    go_s        = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (single_s) begin
          go_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (same_pat_s) begin
          go_s      = 1'b1;
          cnt_new_s = scnt_r + SCNT_ONE;
        end else if (single_s) begin
          go_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HELD: begin
        // Cathode-only changes are deliberately ignored here.
        if (same_anodes_s) begin
          state_nxt_s = ST_HELD;
        end else if (single_s) begin
          go_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    if (go_s) begin
      scnt_nxt_s = cnt_new_s;
      if (cnt_new_s >= SETTLE_MAX) begin
        capture_s   = 1'b1;
        state_nxt_s = ST_HELD;
      end else begin
        state_nxt_s = ST_SETTLE;
      end
    end else begin
      scnt_nxt_s = scnt_r;
    end
  end

  // Frame assembly and timeout bookkeeping.
  always_comb begin
    seen_set_s   = capture_s ? (4'b0001 << digit_s) : 4'b0000;
    frame_done_s = (seen_r == 4'b1111);
    frame_s      = {shadow_r[3], shadow_r[2], shadow_r[1], shadow_r[0]};
    if (capture_s) begin
      tcnt_nxt_s = '0;
    end else if (tcnt_r == TIMEOUT_MAX) begin
      tcnt_nxt_s = TIMEOUT_MAX;
    end else begin
      tcnt_nxt_s = tcnt_r + TCNT_ONE;
    end
  end

  // Input registers plus one-cycle history for stability comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes_r        <= 4'b1111;
      cathodes_r      <= 7'b1111111;
      prev_anodes_r   <= 4'b1111;
      prev_cathodes_r <= 7'b1111111;
    end else begin
      anodes_r        <= anodes;
      cathodes_r      <= cathodes;
      prev_anodes_r   <= anodes_r;
      prev_cathodes_r <= cathodes_r;
    end
  end

  // FSM state, stability counter, shadow slots and seen mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      scnt_r  <= '0;
      seen_r  <= 4'b0000;
      for (int i = 0; i < 4; i++) shadow_r[i] <= 7'b1111111;
    end else begin
      state_r <= state_nxt_s;
      scnt_r  <= scnt_nxt_s;
      // A capture landing on the completion cycle starts the next frame.
      seen_r  <= frame_done_s ? seen_set_s : (seen_r | seen_set_s);
      if (capture_s) shadow_r[digit_s] <= cathodes_r;
    end
  end

  // Frame outputs, decode, timeout/stale and glitch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_raw       <= 28'd0;
      digit_value   <= 16'd0;
      digit_known   <= 4'd0;
      digit_blank   <= 4'd0;
      frame_strobe  <= 1'b0;
      frame_changed <= 1'b0;
      stale         <= 1'b0;
      glitch_count  <= 8'd0;
      tcnt_r        <= '0;
    end else begin
      frame_strobe  <= frame_done_s;
      frame_changed <= frame_done_s && (frame_s != seg_raw);
      if (frame_done_s) begin
        seg_raw <= frame_s;
        for (int i = 0; i < 4; i++) begin
          {digit_known[i], digit_blank[i], digit_value[4*i +: 4]} <= decode_glyph(shadow_r[i]);
        end
      end
      tcnt_r <= tcnt_nxt_s;
      // Frame completion has priority over a coincident timeout.
      if (frame_done_s) begin
        stale <= 1'b0;
      end else if (tcnt_nxt_s == TIMEOUT_MAX) begin
        stale <= 1'b1;
      end
      // Count entries into an illegal pattern, not cycles spent in it.
      if (illegal_s && !same_anodes_s && (glitch_count != 8'hFF)) begin
        glitch_count <= glitch_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  localparam logic [6:0] G0 = 7'h01, G1 = 7'h4F, G2 = 7'h12, G3 = 7'h06;
  localparam logic [6:0] G4 = 7'h4C, G5 = 7'h24, G6 = 7'h20, G7 = 7'h0F;
  localparam logic [6:0] G8 = 7'h00, G9 = 7'h04, GA = 7'h08, GB = 7'h60;
  localparam logic [6:0] GC = 7'h31, GD = 7'h42, GE = 7'h30, GF = 7'h38;
  localparam logic [6:0] GP = 7'h18, GL = 7'h71, GX = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  anodes;
  logic [6:0]  cathodes;
  logic [27:0] seg_raw;
  logic [15:0] digit_value;
  logic [3:0]  digit_known, digit_blank;
  logic        frame_strobe, frame_changed, stale;
  logic [7:0]  glitch_count;

  typedef struct {
    logic [27:0] seg;
    logic [15:0] val;
    logic [3:0]  known;
    logic [3:0]  blank;
    logic        changed;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   strobe_cnt = 0;
  int   saved_cnt;

  seg7_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .anodes(anodes), .cathodes(cathodes),
    .seg_raw(seg_raw), .digit_value(digit_value), .digit_known(digit_known),
    .digit_blank(digit_blank), .frame_strobe(frame_strobe),
    .frame_changed(frame_changed), .stale(stale), .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: every frame_strobe pops one expected frame.
  always @(negedge clk) begin
    if (frame_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {31'd0, frame_strobe}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("seg_raw", {4'd0, seg_raw}, {4'd0, e.seg});
        chk("digit_value", {16'd0, digit_value}, {16'd0, e.val});
        chk("digit_known", {28'd0, digit_known}, {28'd0, e.known});
        chk("digit_blank", {28'd0, digit_blank}, {28'd0, e.blank});
        chk("frame_changed", {31'd0, frame_changed}, {31'd0, e.changed});
      end
    end
  end

  task automatic show(input logic [3:0] an, input logic [6:0] ca, input int n);
    anodes   = an;
    cathodes = ca;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] g3, g2, g1, g0);
    show(4'b1110, g3, 10);
    show(4'b1101, g2, 10);
    show(4'b1011, g1, 10);
    show(4'b0111, g0, 10);
  endtask

  task automatic expect_frame(input logic [6:0] g3, g2, g1, g0, input logic [15:0] val,
                              input logic [3:0] known, input logic [3:0] blank, input logic ch);
    exp_t e;
    e.seg = {g3, g2, g1, g0};
    e.val = val;
    e.known = known;
    e.blank = blank;
    e.changed = ch;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_seg_raw"}, {4'd0, seg_raw}, 32'd0);
    chk({tag, "_value"}, {16'd0, digit_value}, 32'd0);
    chk({tag, "_known"}, {28'd0, digit_known}, 32'd0);
    chk({tag, "_blank"}, {28'd0, digit_blank}, 32'd0);
    chk({tag, "_strobe"}, {31'd0, frame_strobe}, 32'd0);
    chk({tag, "_changed"}, {31'd0, frame_changed}, 32'd0);
    chk({tag, "_stale"}, {31'd0, stale}, 32'd0);
    chk({tag, "_glitch"}, {24'd0, glitch_count}, 32'd0);
  endtask

  task automatic chk_frame_arrived(input string nm);
    chk(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    anodes = 4'b1111;
    cathodes = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // "1234", first frame changes seg_raw
    expect_frame(G1, G2, G3, G4, 16'h1234, 4'hF, 4'h0, 1'b1);
    scan4(G1, G2, G3, G4);
    chk_frame_arrived("frame_1234");
    // repeats: strobe but no change
    expect_frame(G1, G2, G3, G4, 16'h1234, 4'hF, 4'h0, 1'b0);
    expect_frame(G1, G2, G3, G4, 16'h1234, 4'hF, 4'h0, 1'b0);
    scan4(G1, G2, G3, G4);
    scan4(G1, G2, G3, G4);
    chk_frame_arrived("frame_1234_repeat");

    // "5678" with an illegal pattern in the middle of the scan
    expect_frame(G5, G6, G7, G8, 16'h5678, 4'hF, 4'h0, 1'b1);
    show(4'b1110, G5, 10);
    show(4'b1101, G6, 10);
    show(4'b1100, G9, 5);
    show(4'b1011, G7, 10);
    show(4'b0111, G8, 10);
    chk_frame_arrived("frame_5678");
    chk("glitch_one", {24'd0, glitch_count}, 32'd1);

    expect_frame(G9, GA, GB, GC, 16'h9ABC, 4'hF, 4'h0, 1'b1);
    scan4(G9, GA, GB, GC);
    expect_frame(GD, GE, GF, G0, 16'hDEF0, 4'hF, 4'h0, 1'b1);
    scan4(GD, GE, GF, G0);
    chk_frame_arrived("frame_hex_font");

    // "P  1": P unknown, blank, L unknown, 1 known
    expect_frame(GP, GX, GL, G1, 16'h0001, 4'b0001, 4'b0100, 1'b1);
    scan4(GP, GX, GL, G1);
    chk_frame_arrived("frame_P_L1");

    // digit 2 enabled for fewer cycles than the settle window
    saved_cnt = strobe_cnt;
    show(4'b1110, G1, 10);
    show(4'b1101, G2, 3);
    show(4'b1011, G3, 10);
    show(4'b0111, G4, 10);
    chk("short_enable_no_strobe", strobe_cnt, saved_cnt);
    expect_frame(G1, G2, G3, G4, 16'h1234, 4'hF, 4'h0, 1'b1);
    show(4'b1101, G2, 10);
    chk_frame_arrived("short_enable_completes");

    // glitch counter: one per entry, saturating
    show(4'b1111, G0, 2);
    show(4'b1100, G0, 3);
    show(4'b1111, G0, 2);
    chk("glitch_two", {24'd0, glitch_count}, 32'd2);
    for (int i = 0; i < 258; i++) begin
      show(4'b0000, G0, 2);
      show(4'b1111, G0, 1);
    end
    chk("glitch_saturate", {24'd0, glitch_count}, 32'd255);
    chk("stale_after_idle_glitches", {31'd0, stale}, 32'd1);

    // a frame clears stale
    expect_frame(G1, G2, G3, G4, 16'h1234, 4'hF, 4'h0, 1'b0);
    scan4(G1, G2, G3, G4);
    chk_frame_arrived("frame_after_glitch");
    chk("stale_cleared", {31'd0, stale}, 32'd0);

    // timeout
    show(4'b1111, G0, 200);
    chk("stale_not_yet", {31'd0, stale}, 32'd0);
    show(4'b1111, G0, 150);
    chk("stale_set", {31'd0, stale}, 32'd1);
    expect_frame(G1, G2, G3, G4, 16'h1234, 4'hF, 4'h0, 1'b0);
    scan4(G1, G2, G3, G4);
    chk_frame_arrived("frame_resume");
    chk("stale_cleared_resume", {31'd0, stale}, 32'd0);

    // reset after two captures discards the partial frame
    show(4'b1110, G9, 10);
    show(4'b1101, GA, 10);
    rst = 1'b1;
    anodes = 4'b1111;
    @(posedge clk);
    #1;
    chk_all_zero("midscan_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    saved_cnt = strobe_cnt;
    show(4'b1011, GB, 10);
    show(4'b0111, GC, 10);
    chk("after_reset_partial", strobe_cnt, saved_cnt);
    expect_frame(G9, GA, GB, GC, 16'h9ABC, 4'hF, 4'h0, 1'b1);
    scan4(G9, GA, GB, GC);
    show(4'b1111, G0, 5);
    chk_frame_arrived("frame_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
